// File: rtl/cp0_exc_commit_pkg.sv
// CP0 register numbers, field constants and exception codes shared by the
// exception commit block, its timer and the bench.
package cp0_exc_commit_pkg;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC0_0380;

    function automatic logic is_addr_exc(input logic [4:0] code);
        return (code == EXC_ADEL) || (code == EXC_ADES);
    endfunction

endpackage

// File: rtl/cp0_exc_commit_if.sv
// Commit bundle, MTC0/MFC0 port and front-end controls of the CP0 block.
interface cp0_exc_commit_if;

    logic        commit_valid;
    logic [31:0] pc;
    logic [31:0] badvaddr;
    logic [4:0]  excCode;
    logic        is_exc;
    logic        is_in_ds;
    logic        is_eret;
    logic [5:0]  hw_int;
    logic        mtc0_wen;
    logic [4:0]  mtc0_addr;
    logic [31:0] mtc0_wdata;
    logic [4:0]  mfc0_addr;
    logic [31:0] mfc0_rdata;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        int_req;
    logic [31:0] epc_out;

    modport master (
        output commit_valid, pc, badvaddr, excCode, is_exc, is_in_ds,
        output is_eret, hw_int, mtc0_wen, mtc0_addr, mtc0_wdata,
        output mfc0_addr,
        input  mfc0_rdata, flush, redirect_pc, int_req, epc_out
    );

    modport slave (
        input  commit_valid, pc, badvaddr, excCode, is_exc, is_in_ds,
        input  is_eret, hw_int, mtc0_wen, mtc0_addr, mtc0_wdata,
        input  mfc0_addr,
        output mfc0_rdata, flush, redirect_pc, int_req, epc_out
    );

endinterface

// File: rtl/cp0_exc_commit_timer.sv
// CP0 Count/Compare timer: prescaled Count, Compare match sets TI until
// Compare is rewritten.
module cp0_exc_commit_timer #(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    logic presc;
    logic tick;

    assign tick = (COUNT_DIV == 1) ? 1'b1 : presc;

    always_ff @(posedge clk) begin
        if (reset) begin
            presc   <= 1'b0;
            count   <= '0;
            compare <= '0;
            ti      <= 1'b0;
        end else begin
            // A software write restarts the prescaler phase.
            if (count_we) begin
                count <= wdata;
                presc <= 1'b0;
            end else begin
                presc <= ~presc;
                if (tick) count <= count + 32'd1;
            end
            if (compare_we) begin
                compare <= wdata;
                ti      <= 1'b0;
            end else if (count == compare) begin
                ti <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cp0_exc_commit.sv
// CP0 register file and exception/ERET commit point: updates CP0 state,
// issues the one-cycle flush/redirect and raises the interrupt request.
module cp0_exc_commit
    import cp0_exc_commit_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
    parameter int          COUNT_DIV  = 2
) (
    input logic               clk,
    input logic               reset,
    cp0_exc_commit_if.slave   bus
);

    logic        exc_c, eret_c, wen;
    logic [31:0] badvaddr_q, epc_q, redir_q;
    logic [7:0]  im;
    logic        exl, ie, bd, flush_q, ti;
    logic [4:0]  code;
    logic [5:0]  ip_hw;
    logic [1:0]  ip_sw;
    logic [31:0] count, compare;
    logic [31:0] status_r, cause_r, rdata;

    assign exc_c  = bus.commit_valid & bus.is_exc;
    assign eret_c = bus.commit_valid & bus.is_eret & ~bus.is_exc;
    // An exception in the same cycle swallows any MTC0.
    assign wen    = bus.mtc0_wen & ~exc_c;

    cp0_exc_commit_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .count_we   (wen && bus.mtc0_addr == CP0_COUNT),
        .compare_we (wen && bus.mtc0_addr == CP0_COMPARE),
        .wdata      (bus.mtc0_wdata),
        .count      (count),
        .compare    (compare),
        .ti         (ti)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            badvaddr_q <= '0;
            epc_q      <= '0;
            redir_q    <= '0;
            im         <= '0;
            exl        <= 1'b0;
            ie         <= 1'b0;
            bd         <= 1'b0;
            code       <= '0;
            ip_hw      <= '0;
            ip_sw      <= '0;
            flush_q    <= 1'b0;
        end else begin
            flush_q <= 1'b0;
            ip_hw   <= {bus.hw_int[5] | ti, bus.hw_int[4:0]};
            if (wen) begin
                unique case (1'b1)
                    (bus.mtc0_addr == CP0_STATUS): begin
                        im  <= bus.mtc0_wdata[15:8];
                        exl <= bus.mtc0_wdata[1];
                        ie  <= bus.mtc0_wdata[0];
                    end
                    (bus.mtc0_addr == CP0_CAUSE): ip_sw <= bus.mtc0_wdata[9:8];
                    (bus.mtc0_addr == CP0_EPC):   epc_q <= bus.mtc0_wdata;
                    default: ;
                endcase
            end
            if (exc_c) begin
                exl <= 1'b1;
                if (!exl) begin
                    epc_q <= bus.pc;
                    bd    <= bus.is_in_ds;
                end
                code <= bus.excCode;
                if (is_addr_exc(bus.excCode)) badvaddr_q <= bus.badvaddr;
                flush_q <= 1'b1;
                redir_q <= EXC_VECTOR;
            end else if (eret_c) begin
                exl     <= 1'b0;
                flush_q <= 1'b1;
                redir_q <= epc_q;
            end
        end
    end

    assign status_r = {9'b0, 1'b1, 6'b0, im, 6'b0, exl, ie};
    assign cause_r  = {bd, ti, 14'b0, ip_hw, ip_sw, 1'b0, code, 2'b0};

    always_comb begin
        rdata = '0;
        unique case (1'b1)
            (bus.mfc0_addr == CP0_BADVADDR): rdata = badvaddr_q;
            (bus.mfc0_addr == CP0_COUNT):    rdata = count;
            (bus.mfc0_addr == CP0_COMPARE):  rdata = compare;
            (bus.mfc0_addr == CP0_STATUS):   rdata = status_r;
            (bus.mfc0_addr == CP0_CAUSE):    rdata = cause_r;
            (bus.mfc0_addr == CP0_EPC):      rdata = epc_q;
            default:                         rdata = '0;
        endcase
    end

    assign bus.mfc0_rdata  = rdata;
    assign bus.flush       = flush_q;
    assign bus.redirect_pc = redir_q;
    assign bus.epc_out     = epc_q;
    assign bus.int_req     = ie & ~exl & |(im & {ip_hw, ip_sw});

endmodule

// File: tb/tb_cp0_exc_commit.sv
// Directed and randomized bench for cp0_exc_commit against a cycle-level
// model of the CP0 architectural state.
module tb_cp0_exc_commit;

    localparam logic [31:0] VEC = 32'hBFC0_0380;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    cp0_exc_commit_if bus ();

    cp0_exc_commit #(.EXC_VECTOR(VEC), .COUNT_DIV(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Architectural model; Count is base plus half the edges since last load.
    logic [7:0]  m_im;
    logic        m_exl, m_ie, m_bd, m_ti, m_flush;
    logic [4:0]  m_code;
    logic [5:0]  m_hw;
    logic [1:0]  m_sw;
    logic [31:0] m_epc, m_bad, m_base, m_cmp, m_redir;
    int unsigned m_edges;

    function automatic logic [31:0] mcount();
        return m_base + 32'(m_edges >> 1);
    endfunction

    function automatic logic m_int();
        return m_ie & ~m_exl & |(m_im & {m_hw, m_sw});
    endfunction

    function automatic logic [31:0] mread(input logic [4:0] a);
        case (a)
            5'd8:    return m_bad;
            5'd9:    return mcount();
            5'd11:   return m_cmp;
            5'd12:   return {9'b0, 1'b1, 6'b0, m_im, 6'b0, m_exl, m_ie};
            5'd13:   return {m_bd, m_ti, 14'b0, m_hw, m_sw, 1'b0, m_code, 2'b0};
            5'd14:   return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    task automatic mdl_reset();
        m_im = '0; m_exl = 0; m_ie = 0; m_bd = 0; m_ti = 0; m_flush = 0;
        m_code = '0; m_hw = '0; m_sw = '0; m_epc = '0; m_bad = '0;
        m_base = '0; m_cmp = '0; m_redir = '0; m_edges = 0;
    endtask

    task automatic mdl_step();
        logic [31:0] cnt, o_epc, wd;
        logic        o_ti, o_exl, ex, er, we;
        logic [4:0]  wa;
        cnt = mcount(); o_ti = m_ti; o_exl = m_exl; o_epc = m_epc;
        ex = bus.commit_valid & bus.is_exc;
        er = bus.commit_valid & bus.is_eret & ~bus.is_exc;
        we = bus.mtc0_wen & ~ex;
        wa = bus.mtc0_addr; wd = bus.mtc0_wdata;
        if (reset) begin
            mdl_reset();
            return;
        end
        m_flush = 0;
        if (we && wa == 5'd9) begin
            m_base = wd; m_edges = 0;
        end else begin
            m_edges++;
        end
        if (we && wa == 5'd11) begin
            m_cmp = wd; m_ti = 0;
        end else if (cnt == m_cmp) begin
            m_ti = 1;
        end
        m_hw = {bus.hw_int[5] | o_ti, bus.hw_int[4:0]};
        if (we) begin
            case (wa)
                5'd12: begin m_im = wd[15:8]; m_exl = wd[1]; m_ie = wd[0]; end
                5'd13: m_sw = wd[9:8];
                5'd14: m_epc = wd;
                default: ;
            endcase
        end
        if (ex) begin
            m_exl = 1;
            if (!o_exl) begin
                m_epc = bus.pc; m_bd = bus.is_in_ds;
            end
            m_code = bus.excCode;
            if (bus.excCode == 5'd4 || bus.excCode == 5'd5) m_bad = bus.badvaddr;
            m_flush = 1; m_redir = VEC;
        end else if (er) begin
            m_exl = 0; m_flush = 1; m_redir = o_epc;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        mdl_step();
        @(posedge clk);
        #1;
        bus.commit_valid = 0; bus.is_exc = 0; bus.is_eret = 0; bus.mtc0_wen = 0;
        chk("flush", 32'(bus.flush), 32'(m_flush));
        chk("redirect", bus.redirect_pc, m_redir);
        chk("epc_out", bus.epc_out, m_epc);
        chk("int_req", 32'(bus.int_req), 32'(m_int()));
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        bus.mfc0_addr = a;
        #1;
        d = bus.mfc0_rdata;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        bus.mtc0_wen = 1; bus.mtc0_addr = a; bus.mtc0_wdata = d;
    endtask

    task automatic commit(input logic [31:0] p, input logic [4:0] c,
                          input logic [31:0] bv, input logic ds, input logic er);
        bus.commit_valid = 1; bus.is_exc = ~er; bus.is_eret = er;
        bus.pc = p; bus.excCode = c; bus.badvaddr = bv; bus.is_in_ds = ds;
    endtask

    initial begin
        logic [31:0] d;
        logic [4:0]  addrs [7];
        logic [4:0]  a;
        int          n;
        addrs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3};
        bus.commit_valid = 0; bus.pc = '0; bus.badvaddr = '0; bus.excCode = '0;
        bus.is_exc = 0; bus.is_in_ds = 0; bus.is_eret = 0; bus.hw_int = '0;
        bus.mtc0_wen = 0; bus.mtc0_addr = '0; bus.mtc0_wdata = '0; bus.mfc0_addr = '0;
        reset = 1;
        cyc(); cyc();
        reset = 0;
        rd(5'd12, d); chk("rst_status", d, 32'h0040_0000);
        rd(5'd9, d);  chk("rst_count", d, 32'h0);
        chk("rst_flush", 32'(bus.flush), 32'h0);

        commit(32'hBFC0_1000, 5'd4, 32'h3, 1'b1, 1'b0);
        cyc();
        chk("exc_flush", 32'(bus.flush), 32'h1);
        chk("exc_redir", bus.redirect_pc, 32'hBFC0_0380);
        chk("exc_epc", bus.epc_out, 32'hBFC0_1000);
        rd(5'd8, d);  chk("exc_badv", d, 32'h3);
        rd(5'd13, d); chk("exc_bd", 32'(d[31]), 32'h1);
        chk("exc_code", 32'(d[6:2]), 32'h4);
        rd(5'd12, d); chk("exc_exl", 32'(d[1]), 32'h1);
        cyc();
        chk("flush_drop", 32'(bus.flush), 32'h0);

        commit(32'h1234, 5'd12, 32'hDEAD_0000, 1'b0, 1'b0);
        cyc();
        chk("exc2_epc", bus.epc_out, 32'hBFC0_1000);
        chk("exc2_flush", 32'(bus.flush), 32'h1);
        rd(5'd13, d); chk("exc2_code", 32'(d[6:2]), 32'd12);
        rd(5'd8, d);  chk("exc2_badv", d, 32'h3);

        mtc0(5'd14, 32'hBFC0_2000);
        cyc();
        commit(32'h0, 5'd0, 32'h0, 1'b0, 1'b1);
        mtc0(5'd14, 32'h1111_0000);
        cyc();
        chk("eret_flush", 32'(bus.flush), 32'h1);
        chk("eret_redir", bus.redirect_pc, 32'hBFC0_2000);
        chk("eret_epc_new", bus.epc_out, 32'h1111_0000);
        rd(5'd12, d); chk("eret_exl", 32'(d[1]), 32'h0);

        mtc0(5'd11, 32'd10); cyc();
        mtc0(5'd9, 32'd0);   cyc();
        mtc0(5'd12, 32'h0000_8001); cyc();
        chk("tmr_quiet", 32'(bus.int_req), 32'h0);
        n = 0;
        while (!bus.int_req && n < 60) begin
            cyc();
            n++;
        end
        chk("tmr_int", 32'(bus.int_req), 32'h1);
        chk("tmr_lat", 32'(n >= 18 && n <= 24), 32'h1);
        rd(5'd13, d); chk("tmr_ti", 32'(d[30]), 32'h1);
        mtc0(5'd11, 32'h0010_0000); cyc();
        rd(5'd13, d); chk("tmr_ti_clr", 32'(d[30]), 32'h0);
        cyc();
        chk("tmr_int_clr", 32'(bus.int_req), 32'h0);

        commit(32'h2000, 5'd10, 32'h0, 1'b0, 1'b0);
        mtc0(5'd12, 32'h0);
        cyc();
        rd(5'd12, d); chk("exc_vs_mtc0", d, 32'h0040_8003);
        bus.hw_int = 6'b000100;
        mtc0(5'd12, 32'h0000_1001);
        cyc();
        chk("hw_int_req", 32'(bus.int_req), 32'h1);
        bus.hw_int = '0;

        commit(32'h3000, 5'd4, 32'h77, 1'b0, 1'b0);
        reset = 1;
        cyc();
        reset = 0;
        chk("rst_cancel", 32'(bus.flush), 32'h0);
        rd(5'd12, d); chk("rst_mid_st", d, 32'h0040_0000);

        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(99) == 0);
            if ($urandom_range(3) == 0) begin
                bus.commit_valid = 1;
                bus.is_exc = 1'($urandom_range(1));
                bus.is_eret = 1'($urandom_range(1));
                bus.pc = $urandom; bus.badvaddr = $urandom;
                bus.is_in_ds = 1'($urandom_range(1));
                bus.excCode = $urandom_range(1) ? 5'(4 + $urandom_range(1))
                                                : 5'($urandom_range(31));
            end
            if ($urandom_range(3) == 0) begin
                a = addrs[$urandom_range(6)];
                mtc0(a, (a == 5'd9) ? m_cmp - 32'($urandom_range(6)) : $urandom);
            end
            if ($urandom_range(7) == 0) bus.hw_int = 6'($urandom);
            cyc();
            a = addrs[$urandom_range(6)];
            rd(a, d);
            chk("rand_rd", d, mread(a));
        end
        reset = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
